rgb_color_classifier: RTL
=========================

Name: rgb_color_classifier

Overview:
Downstream consumer of the TCS34725 reader's 16-bit red/green/blue words. Box-car averages 2^AVG_LOG2 consecutive RGB samples per channel, then classifies the averaged colour as DARK, RED, GREEN, BLUE or WHITE. Produces registered averages, a 3-bit colour code and a one-cycle result strobe for downstream logic (LED driver, sorter control).

Parameters:
AVG_LOG2, 2, log2 of samples per averaging window; legal range 0..4 (1..16 samples)
DARK_THRESH, 16'd64, all three averages strictly below this value -> DARK
WHITE_SHIFT, 3, WHITE when (max-min) < (max >> WHITE_SHIFT), i.e. spread within 12.5% of max by default
STABLE_COUNT, 2, consecutive identical classifications required before color_code changes (used only with RGB_STABILITY_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
rgb_valid  input  1  one-cycle strobe: red_in/green_in/blue_in hold a new sample
red_in  input  16  red channel sample
green_in  input  16  green channel sample
blue_in  input  16  blue channel sample
avg_red  output  16  averaged red, updated at out_valid
avg_green  output  16  averaged green
avg_blue  output  16  averaged blue
color_code  output  3  0=DARK 1=RED 2=GREEN 3=BLUE 4=WHITE; 5..7 never driven
out_valid  output  1  one-cycle pulse: window result ready
sample_drop  output  1  one-cycle pulse: rgb_valid arrived while not in ACCUM

Behaviour:
- Reset (rst low, asynchronous): state=ACCUM, accumulators=0, sample count=0, all outputs 0 (color_code=DARK, out_valid=0, sample_drop=0); stability counter and candidate cleared. Reset mid-window discards the partial window entirely.
- Accumulators: 16+AVG_LOG2 bits per channel, unsigned; cannot overflow. Sample counter: AVG_LOG2+1 bits.
- FSM states:
  ACCUM: on rgb_valid add each input to its accumulator, increment count. When the accepted sample is the 2^AVG_LOG2-th -> AVERAGE. No rgb_valid -> stay.
  AVERAGE (1 cycle): avg_x <= acc_x >> AVG_LOG2 (truncating), internal registers; clear accumulators and count -> CLASSIFY.
  CLASSIFY (1 cycle): compute max/min of the three averages; register color_code, publish avg_* outputs, pulse out_valid -> ACCUM.
- Latency: final sample accepted in cycle T -> avg_* and color_code update and out_valid high in cycle T+2, exactly one cycle. AVG_LOG2=0: every sample produces a result 2 cycles later.
- Classification priority, evaluated in order: (1) avg_red, avg_green, avg_blue all < DARK_THRESH -> DARK; (2) (max-min) < (max >> WHITE_SHIFT) -> WHITE; (3) channel equal to max -> RED, GREEN, BLUE; ties resolved red > green > blue.
- rgb_valid in AVERAGE or CLASSIFY: the sample is not accumulated; sample_drop pulses in the same cycle. The upstream reader's sample spacing (many I2C transactions) makes this a fault indicator only.
- Outputs hold their last values between out_valid pulses.
- All arithmetic is unsigned; max-min never negative.

Optional Feature:
RGB_STABILITY_EN
- Defined: a candidate register and a counter track the raw classification. color_code is updated only once the same raw class has been produced for STABLE_COUNT consecutive windows. A differing class restarts the count at 1 with the new candidate. avg_* and out_valid behave identically in both builds.
- Undefined: color_code follows every window's raw class; the candidate register and counter are not present.

Test Plan:
- AVG_LOG2=2: four samples with r=1000, g=200, b=100 -> out_valid 2 cycles after the 4th strobe; avg=1000/200/100; color_code=1 (RED).
- Averaging truncation: r=100,200,300,403 with g=b=0 -> avg_red=250; color_code=1.
- WHITE: four samples with r=800, g=850, b=780 -> spread 70 < 106 -> color_code=4. DARK: 10/20/30 -> color_code=0.
- Tie: r=g=500, b=0 -> RED (priority). g=b=700, r=0 -> GREEN.
- Reset mid-window: 2 samples of r=4000, assert rst, release, then 4 samples of b=900 with r=g=0 -> avg_red=0, avg_blue=900, code=3; during reset all outputs read 0.
- Drop and stability: strobe rgb_valid in the cycle after the 4th sample -> sample_drop=1, not counted. With RGB_STABILITY_EN and STABLE_COUNT=2: windows RED, GREEN, GREEN -> color_code stays 1 until the 3rd out_valid, then becomes 2.

Source files
------------

// File: rtl/rgb_color_classifier_if.sv
// Sample/result bus between the TCS34725 reader side and the RGB colour classifier.
// master drives samples and observes results; slave is the classifier.
interface rgb_color_classifier_if;
    logic        rgb_valid;
    logic [15:0] red_in;
    logic [15:0] green_in;
    logic [15:0] blue_in;
    logic [15:0] avg_red;
    logic [15:0] avg_green;
    logic [15:0] avg_blue;
    logic [2:0]  color_code;
    logic        out_valid;
    logic        sample_drop;

    modport master (
        output rgb_valid, red_in, green_in, blue_in,
        input  avg_red, avg_green, avg_blue, color_code, out_valid, sample_drop
    );

    modport slave (
        input  rgb_valid, red_in, green_in, blue_in,
        output avg_red, avg_green, avg_blue, color_code, out_valid, sample_drop
    );
endinterface

// File: rtl/rgb_color_classifier.sv
// Box-car averages 2^AVG_LOG2 RGB samples and classifies the result as DARK/RED/GREEN/BLUE/WHITE.
// Optional macro RGB_STABILITY_EN: color_code changes only after STABLE_COUNT identical windows.
module rgb_color_classifier #(
    parameter int unsigned AVG_LOG2    = 2,
    parameter logic [15:0] DARK_THRESH = 16'd64,
    parameter int unsigned WHITE_SHIFT = 3
`ifdef RGB_STABILITY_EN
    ,
    parameter int unsigned STABLE_COUNT = 2
`endif
) (
    input logic             clk,
    input logic             rst,
    rgb_color_classifier_if.slave bus
);

    localparam int unsigned ACC_W     = 16 + AVG_LOG2;
    localparam int unsigned CNT_W     = AVG_LOG2 + 1;
    localparam int unsigned N_SAMPLES = 1 << AVG_LOG2;

    typedef enum logic [1:0] {
        ST_ACCUM    = 2'd0,
        ST_AVERAGE  = 2'd1,
        ST_CLASSIFY = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CC_DARK  = 3'd0,
        CC_RED   = 3'd1,
        CC_GREEN = 3'd2,
        CC_BLUE  = 3'd3,
        CC_WHITE = 3'd4
    } color_e;

    state_e             state_q, state_d;
    logic               accept_c, do_avg_c, do_cls_c, drop_c;

    logic [ACC_W-1:0]   acc_r_q, acc_g_q, acc_b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        int_r_q, int_g_q, int_b_q;
    logic [15:0]        avg_r_q, avg_g_q, avg_b_q;
    color_e             color_q;
    logic               out_valid_q, sample_drop_q;

    logic [15:0]        max_c, min_c;
    color_e             raw_c;

`ifdef RGB_STABILITY_EN
    localparam int unsigned STAB_W = (STABLE_COUNT < 2) ? 1 : $clog2(STABLE_COUNT + 1);
    color_e             cand_q;
    logic [STAB_W-1:0]  stab_cnt_q;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_ACCUM;
        else      state_q <= state_d;
    end

    // Next-state and per-state datapath strobes
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        do_avg_c = 1'b0;
        do_cls_c = 1'b0;
        drop_c   = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (bus.rgb_valid) begin
                    accept_c = 1'b1;
                    if (cnt_q + CNT_W'(1) == CNT_W'(N_SAMPLES)) state_d = ST_AVERAGE;
                end
            end
            ST_AVERAGE: begin
                do_avg_c = 1'b1;
                drop_c   = bus.rgb_valid;
                state_d  = ST_CLASSIFY;
            end
            ST_CLASSIFY: begin
                do_cls_c = 1'b1;
                drop_c   = bus.rgb_valid;
                state_d  = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // Raw classification of the internal averages; ties favour red, then green
    always_comb begin
        max_c = int_r_q;
        if (int_g_q > max_c) max_c = int_g_q;
        if (int_b_q > max_c) max_c = int_b_q;
        min_c = int_r_q;
        if (int_g_q < min_c) min_c = int_g_q;
        if (int_b_q < min_c) min_c = int_b_q;

        raw_c = CC_DARK;
        if (int_r_q < DARK_THRESH && int_g_q < DARK_THRESH && int_b_q < DARK_THRESH)
            raw_c = CC_DARK;
        else if ((max_c - min_c) < (max_c >> WHITE_SHIFT))
            raw_c = CC_WHITE;
        else if (int_r_q == max_c)
            raw_c = CC_RED;
        else if (int_g_q == max_c)
            raw_c = CC_GREEN;
        else
            raw_c = CC_BLUE;
    end

    // Accumulate, average and publish
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r_q       <= '0;
            acc_g_q       <= '0;
            acc_b_q       <= '0;
            cnt_q         <= '0;
            int_r_q       <= '0;
            int_g_q       <= '0;
            int_b_q       <= '0;
            avg_r_q       <= '0;
            avg_g_q       <= '0;
            avg_b_q       <= '0;
            color_q       <= CC_DARK;
            out_valid_q   <= 1'b0;
            sample_drop_q <= 1'b0;
`ifdef RGB_STABILITY_EN
            cand_q        <= CC_DARK;
            stab_cnt_q    <= '0;
`endif
        end else begin
            out_valid_q   <= 1'b0;
            sample_drop_q <= drop_c;

            if (accept_c) begin
                acc_r_q <= acc_r_q + ACC_W'(bus.red_in);
                acc_g_q <= acc_g_q + ACC_W'(bus.green_in);
                acc_b_q <= acc_b_q + ACC_W'(bus.blue_in);
                cnt_q   <= cnt_q + CNT_W'(1);
            end

            if (do_avg_c) begin
                int_r_q <= 16'(acc_r_q >> AVG_LOG2);
                int_g_q <= 16'(acc_g_q >> AVG_LOG2);
                int_b_q <= 16'(acc_b_q >> AVG_LOG2);
                acc_r_q <= '0;
                acc_g_q <= '0;
                acc_b_q <= '0;
                cnt_q   <= '0;
            end

            if (do_cls_c) begin
                avg_r_q     <= int_r_q;
                avg_g_q     <= int_g_q;
                avg_b_q     <= int_b_q;
                out_valid_q <= 1'b1;
`ifdef RGB_STABILITY_EN
                // Candidate must repeat STABLE_COUNT windows before it reaches color_code
                if (raw_c == cand_q) begin
                    if (32'(stab_cnt_q) < STABLE_COUNT) stab_cnt_q <= stab_cnt_q + STAB_W'(1);
                    if (32'(stab_cnt_q) + 32'd1 >= STABLE_COUNT) color_q <= raw_c;
                end else begin
                    cand_q     <= raw_c;
                    stab_cnt_q <= STAB_W'(1);
                    if (STABLE_COUNT <= 32'd1) color_q <= raw_c;
                end
`else
                color_q <= raw_c;
`endif
            end
        end
    end

    assign bus.avg_red     = avg_r_q;
    assign bus.avg_green   = avg_g_q;
    assign bus.avg_blue    = avg_b_q;
    assign bus.color_code  = color_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.sample_drop = sample_drop_q;

endmodule
